codec_intf: RTL and testbench

- I2S-style master interface between the CS4272 codec and the Equalizer filter datapath.
- Generates MCLK/SCLK/LRCLK from the 50 MHz system clock, giving fs = 50 MHz/2048 ≈ 24414 Hz.
- Deserializes SDout into 16-bit signed left/right samples for the filter banks (upstream of the equalizer core).
- Serializes the equalized left/right samples back onto SDin.

---
 rtl/codec_pkg.sv | 29 ++
 rtl/codec_clkgen.sv | 78 +++++++
 rtl/codec_intf.sv | 154 +++++++++++++++
 tb/tb_codec_intf.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/codec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : codec_pkg
//  Description : Shared constants and types for the CS4272 I2S master
//                interface (counter layout, slot numbering, sample type).
//  Revision    : 1.0  initial release
// ============================================================================
package codec_pkg;

    // Sample width taken from the MSB end of each 32-bit slot.
    localparam int SMPL_W    = 16;

    // Free-running frame counter layout.
    localparam int CNT_W     = 11;
    localparam int MCLK_BIT  = 1;
    localparam int SCLK_BIT  = 4;
    localparam int LRCLK_BIT = 10;

    // Width of the bit-slot index held in cnt[LRCLK_BIT-1:SCLK_BIT+1].
    localparam int SLOT_W    = LRCLK_BIT - SCLK_BIT - 1;

    // I2S puts the MSB one SCLK after the LRCLK edge.
    localparam int MSB_SLOT  = 1;
    localparam int LSB_SLOT  = MSB_SLOT + SMPL_W - 1;

    typedef logic signed [SMPL_W-1:0] smpl_t;

endpackage : codec_pkg
`default_nettype wire

// File: rtl/codec_clkgen.sv
`default_nettype none
// ============================================================================
//  Module      : codec_clkgen
//  Description : Frame counter and clock generator for the codec link.
//                Produces MCLK/SCLK/LRCLK, the codec reset, the slot index,
//                the SCLK rise/fall event strobes and the startup qualifier.
//  Revision    : 1.0  initial release
// ============================================================================
module codec_clkgen
    import codec_pkg::*;
#(
    parameter int STARTUP_FRAMES = 2
) (
    input  logic              clk,
    input  logic              RST_n,
    output logic              MCLK_o,
    output logic              SCLK_o,
    output logic              LRCLK_o,
    output logic              RSTn_o,
    output logic [SLOT_W-1:0] slot_o,
    output logic              half_o,
    output logic              rise_o,
    output logic              fall_o,
    output logic              wrap_o,
    output logic              started_o
);

    // Low SCLK_BIT+1 counter bits pattern just before SCLK goes high / low.
    localparam logic [SCLK_BIT:0] RISE_PAT = {1'b0, {SCLK_BIT{1'b1}}};
    localparam logic [SCLK_BIT:0] FALL_PAT = {1'b1, {SCLK_BIT{1'b1}}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             mclk_q;
    logic             sclk_q;
    logic             lrclk_q;
    logic             rstn_q;
    logic [1:0]       frm_q;

    assign cnt_d = cnt_q + CNT_W'(1);

    // Counter, clock outputs (registered copies of the next count) and the
    // startup bookkeeping that advances once per completed frame.
    always_ff @(posedge clk) begin
        if (!RST_n) begin
            cnt_q   <= '0;
            mclk_q  <= 1'b0;
            sclk_q  <= 1'b0;
            lrclk_q <= 1'b0;
            rstn_q  <= 1'b0;
            frm_q   <= 2'd0;
        end else begin
            cnt_q   <= cnt_d;
            mclk_q  <= cnt_d[MCLK_BIT];
            sclk_q  <= cnt_d[SCLK_BIT];
            lrclk_q <= cnt_d[LRCLK_BIT];
            if (wrap_o) begin
                rstn_q <= 1'b1;
                if (frm_q != 2'b11) begin
                    frm_q <= frm_q + 2'd1;
                end
            end
        end
    end

    assign MCLK_o    = mclk_q;
    assign SCLK_o    = sclk_q;
    assign LRCLK_o   = lrclk_q;
    assign RSTn_o    = rstn_q;
    assign slot_o    = cnt_q[LRCLK_BIT-1:SCLK_BIT+1];
    assign half_o    = cnt_q[LRCLK_BIT];
    assign rise_o    = (cnt_q[SCLK_BIT:0] == RISE_PAT);
    assign fall_o    = (cnt_q[SCLK_BIT:0] == FALL_PAT);
    assign wrap_o    = (cnt_q == '1);
    assign started_o = (int'(frm_q) >= STARTUP_FRAMES);

endmodule : codec_clkgen
`default_nettype wire

// File: rtl/codec_intf.sv
`default_nettype none
// ============================================================================
//  Module      : codec_intf
//  Description : I2S master between the CS4272 codec and the equalizer.
//                Deserializes SDout into left/right samples with a vld
//                strobe and serializes lft_in/rht_in onto SDin.
//  Revision    : 1.0  initial release
// ============================================================================
module codec_intf #(
    parameter int SMPL_W         = 16,
    parameter int STARTUP_FRAMES = 2
) (
    input  logic              clk,
    input  logic              RST_n,
    output logic              MCLK,
    output logic              SCLK,
    output logic              LRCLK,
    output logic              RSTn,
    input  logic              SDout,
    output logic              SDin,
    output logic [SMPL_W-1:0] lft_out,
    output logic [SMPL_W-1:0] rht_out,
    output logic              vld,
    input  logic [SMPL_W-1:0] lft_in,
    input  logic [SMPL_W-1:0] rht_in
);

    import codec_pkg::*;

    // Receive slots MSB_SLOT..RX_LAST carry the sample, MSB first.
    localparam logic [SLOT_W-1:0] RX_FIRST  = SLOT_W'(MSB_SLOT);
    localparam logic [SLOT_W-1:0] RX_LAST   = SLOT_W'(MSB_SLOT + SMPL_W - 1);
    // Transmit: MSB is launched on the slot-0 fall, remaining bits on the
    // falls of slots 1..SMPL_W-1 so the LSB is sampled in slot SMPL_W.
    localparam logic [SLOT_W-1:0] TX_SHIFT  = SLOT_W'(SMPL_W - 1);
    localparam logic [SLOT_W-1:0] TX_IDLE   = SLOT_W'(SMPL_W);

    logic [SLOT_W-1:0] w_slot;
    logic              w_half;
    logic              w_rise;
    logic              w_fall;
    logic              w_wrap;
    logic              w_started;

    codec_clkgen #(
        .STARTUP_FRAMES (STARTUP_FRAMES)
    ) u_clkgen (
        .clk       (clk),
        .RST_n     (RST_n),
        .MCLK_o    (MCLK),
        .SCLK_o    (SCLK),
        .LRCLK_o   (LRCLK),
        .RSTn_o    (RSTn),
        .slot_o    (w_slot),
        .half_o    (w_half),
        .rise_o    (w_rise),
        .fall_o    (w_fall),
        .wrap_o    (w_wrap),
        .started_o (w_started)
    );

    // ------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------
    logic [SMPL_W-1:0] rx_q;
    logic [SMPL_W-1:0] rx_d;
    logic [SMPL_W-1:0] lft_hold_q;
    logic [SMPL_W-1:0] lft_out_q;
    logic [SMPL_W-1:0] rht_out_q;
    logic              pend_q;
    logic              vld_q;
    logic              w_rx_shift;
    logic              w_rx_last;

    assign rx_d       = {rx_q[SMPL_W-2:0], SDout};
    assign w_rx_shift = w_rise && (w_slot >= RX_FIRST) && (w_slot <= RX_LAST);
    assign w_rx_last  = w_rise && (w_slot == RX_LAST);

    // Shift in SDout on SCLK rise, park the left word, and publish the pair
    // one cycle after the right word completes.
    always_ff @(posedge clk) begin
        if (!RST_n) begin
            rx_q       <= '0;
            lft_hold_q <= '0;
            lft_out_q  <= '0;
            rht_out_q  <= '0;
            pend_q     <= 1'b0;
            vld_q      <= 1'b0;
        end else begin
            pend_q <= 1'b0;
            vld_q  <= 1'b0;
            if (w_rx_shift) begin
                rx_q <= rx_d;
            end
            if (w_rx_last && !w_half) begin
                lft_hold_q <= rx_d;
            end
            if (w_rx_last && w_half) begin
                pend_q <= 1'b1;
            end
            if (pend_q) begin
                lft_out_q <= lft_hold_q;
                rht_out_q <= rx_q;
                vld_q     <= w_started;
            end
        end
    end

    assign lft_out = lft_out_q;
    assign rht_out = rht_out_q;
    assign vld     = vld_q;

    // ------------------------------------------------------------------
    // Transmit path
    // ------------------------------------------------------------------
    logic [SMPL_W-1:0] tx_lft_q;
    logic [SMPL_W-1:0] tx_rht_q;
    logic [SMPL_W-1:0] tx_sh_q;
    logic              sdin_q;
    logic [SMPL_W-1:0] w_tx_sel;

    assign w_tx_sel = w_half ? tx_rht_q : tx_lft_q;

    // Capture the outgoing pair once per frame and shift it out on SCLK fall;
    // the line rests at 0 after the LSB until the next slot load.
    always_ff @(posedge clk) begin
        if (!RST_n) begin
            tx_lft_q <= '0;
            tx_rht_q <= '0;
            tx_sh_q  <= '0;
            sdin_q   <= 1'b0;
        end else begin
            if (w_wrap) begin
                tx_lft_q <= lft_in;
                tx_rht_q <= rht_in;
            end
            if (w_fall) begin
                if (w_slot == '0) begin
                    sdin_q  <= w_tx_sel[SMPL_W-1];
                    tx_sh_q <= {w_tx_sel[SMPL_W-2:0], 1'b0};
                end else if (w_slot <= TX_SHIFT) begin
                    sdin_q  <= tx_sh_q[SMPL_W-1];
                    tx_sh_q <= {tx_sh_q[SMPL_W-2:0], 1'b0};
                end else if (w_slot == TX_IDLE) begin
                    sdin_q  <= 1'b0;
                end
            end
        end
    end

    assign SDin = sdin_q;

endmodule : codec_intf
`default_nettype wire

// File: tb/tb_codec_intf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_codec_intf
//  Description : Self-checking bench for codec_intf. A codec model drives
//                24-bit I2S words; a time-based reference predicts clocks,
//                strobes, received samples and transmitted SDin bits.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_codec_intf;

    logic        clk = 1'b0;
    logic        RST_n;
    logic        MCLK, SCLK, LRCLK, RSTn, SDout, SDin, vld;
    logic [15:0] lft_out, rht_out, lft_in, rht_in;

    always #10 clk = ~clk;

    codec_intf #(.SMPL_W(16), .STARTUP_FRAMES(2)) dut (
        .clk     (clk),
        .RST_n   (RST_n),
        .MCLK    (MCLK),
        .SCLK    (SCLK),
        .LRCLK   (LRCLK),
        .RSTn    (RSTn),
        .SDout   (SDout),
        .SDin    (SDin),
        .lft_out (lft_out),
        .rht_out (rht_out),
        .vld     (vld),
        .lft_in  (lft_in),
        .rht_in  (rht_in)
    );

    int          total = 0;
    int          bad   = 0;
    int          t     = 0;      // clk edges since reset release
    bit          started = 1'b0;
    logic [23:0] l24 [16];       // codec words per frame
    logic [23:0] r24 [16];
    logic [15:0] txl [16];       // words expected on SDin per frame
    logic [15:0] txr [16];
    bit          loopf [16];     // frame runs in SDin->SDout loopback
    bit          loop = 1'b0;
    logic        sd_m = 1'b0;
    logic [15:0] cap = '0, cap_l = '0, cap_r = '0;

    assign SDout = loop ? SDin : sd_m;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h at t=%0d", nm, act, want, t);
        end
    endtask

    task automatic wait_t(input int tt);
        while (t < tt) @(negedge clk);
    endtask

    // Time base and record of what the transmitter must send per frame.
    always @(posedge clk) begin
        if (!RST_n) begin
            t       <= 0;
            started <= 1'b1;
            for (int i = 0; i < 16; i++) begin
                txl[i] <= '0;
                txr[i] <= '0;
            end
        end else begin
            t <= t + 1;
            if ((t % 2048) == 2047) begin
                txl[((t + 1) / 2048) % 16] <= lft_in;
                txr[((t + 1) / 2048) % 16] <= rht_in;
            end
        end
    end

    // Codec ADC model: 24-bit word MSB first starting in slot 1, junk elsewhere.
    always @(negedge clk) begin
        int          c, b, f;
        logic [23:0] wv;
        c  = t % 2048;
        b  = (c >> 5) & 31;
        f  = (t / 2048) % 16;
        wv = ((c >> 10) & 1) ? r24[f] : l24[f];
        if (b >= 1 && b <= 24) sd_m = wv[24 - b];
        else                   sd_m = 1'($urandom % 2);
    end

    // Collect SDin at each SCLK rise of slots 1..16 into per-half words.
    always @(negedge clk) begin
        int b;
        if (started && (t % 32) == 15) begin
            b = ((t % 2048) >> 5) & 31;
            if (b >= 1 && b <= 16) cap = {cap[14:0], SDin};
            if (b == 16) begin
                if (((t % 2048) >> 10) & 1) cap_r = cap;
                else                        cap_l = cap;
            end
        end
    end

    // Reference compare, every cycle once reset has been applied.
    always @(negedge clk) begin
        int          c, b, h, f;
        bit          ev;
        logic [15:0] w, el, er;
        if (started) begin
            c  = t % 2048;
            b  = (c >> 5) & 31;
            h  = (c >> 10) & 1;
            f  = (t / 2048) % 16;
            ev = (c == 'h611) && (t >= 2 * 2048);
            chk("MCLK",  32'(MCLK),  32'((t >> 1) & 1));
            chk("SCLK",  32'(SCLK),  32'((t >> 4) & 1));
            chk("LRCLK", 32'(LRCLK), 32'(h));
            chk("RSTn",  32'(RSTn),  32'(t >= 2048));
            chk("vld",   32'(vld),   32'(ev));
            if (ev) begin
                el = loopf[f] ? txl[f] : l24[f][23:8];
                er = loopf[f] ? txr[f] : r24[f][23:8];
                chk("lft_out", 32'(lft_out), 32'(el));
                chk("rht_out", 32'(rht_out), 32'(er));
            end
            if ((c % 32) == 15) begin
                w = h ? txr[f] : txl[f];
                chk("SDin", 32'(SDin), (b >= 1 && b <= 16) ? 32'(w[16 - b]) : 32'd0);
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        RST_n  = 1'b0;
        lft_in = 16'h8001;
        rht_in = 16'h7FFE;
        for (int i = 0; i < 16; i++) begin
            l24[i] = '0; r24[i] = '0; loopf[i] = 1'b0;
        end
        for (int i = 3; i <= 4; i++) begin
            l24[i] = {16'h1234, 8'($urandom)};
            r24[i] = {16'hA5C3, 8'($urandom)};
        end
        for (int i = 5; i <= 10; i++) begin
            l24[i] = 24'($urandom);
            r24[i] = 24'($urandom);
        end
        loopf[8] = 1'b1;

        repeat (5) @(negedge clk);
        chk("rst_vld",  32'(vld),     32'd0);
        chk("rst_RSTn", 32'(RSTn),    32'd0);
        chk("rst_SDin", 32'(SDin),    32'd0);
        chk("rst_lft",  32'(lft_out), 32'd0);
        chk("rst_rht",  32'(rht_out), 32'd0);
        RST_n = 1'b1;

        wait_t(2047);
        chk("RSTn_before_wrap", 32'(RSTn), 32'd0);
        wait_t(2048);
        chk("RSTn_after_wrap", 32'(RSTn), 32'd1);
        wait_t(2048 + 'h7F0);
        chk("tx_left_8001",  32'(cap_l), 32'h8001);
        chk("tx_right_7FFE", 32'(cap_r), 32'h7FFE);

        for (int f = 2; f <= 7; f++) begin
            wait_t(f * 2048 + 'h612);
            if (f == 3) begin
                chk("rx_left_1234",  32'(lft_out), 32'h1234);
                chk("rx_right_A5C3", 32'(rht_out), 32'hA5C3);
                chk("rx_right_neg",  32'(rht_out[15]), 32'd1);
            end
            wait_t(f * 2048 + 'h620 + int'($urandom_range(0, 'h1D0)));
            if (f == 7) begin
                lft_in = 16'hFE0C;   // -500
                rht_in = 16'h01F4;   //  500
            end else begin
                lft_in = 16'($urandom);
                rht_in = 16'($urandom);
            end
        end

        wait_t(8 * 2048);
        loop = 1'b1;
        wait_t(8 * 2048 + 'h612);
        chk("loop_left_m500",  32'(lft_out), 32'h0000FE0C);
        chk("loop_right_500",  32'(rht_out), 32'h000001F4);
        wait_t(9 * 2048);
        loop = 1'b0;
        wait_t(9 * 2048 + 'h7FE);
        lft_in = 16'h1111;
        wait_t(10 * 2048);
        lft_in = 16'h2222;
        wait_t(10 * 2048 + 'h300);
        chk("tx_capture_at_7FF", 32'(cap_l), 32'h1111);

        wait_t(10 * 2048 + 'h500);
        RST_n = 1'b0;
        for (int i = 0; i < 16; i++) begin
            l24[i] = 24'($urandom); r24[i] = 24'($urandom); loopf[i] = 1'b0;
        end
        @(negedge clk);
        RST_n = 1'b1;
        chk("midrst_vld",   32'(vld),     32'd0);
        chk("midrst_RSTn",  32'(RSTn),    32'd0);
        chk("midrst_LRCLK", 32'(LRCLK),   32'd0);
        chk("midrst_SCLK",  32'(SCLK),    32'd0);
        chk("midrst_SDin",  32'(SDin),    32'd0);
        chk("midrst_lft",   32'(lft_out), 32'd0);
        chk("midrst_rht",   32'(rht_out), 32'd0);

        for (int f = 0; f <= 5; f++) begin
            wait_t(f * 2048 + int'($urandom_range(0, 2040)));
            lft_in = 16'($urandom);
            rht_in = 16'($urandom);
        end
        wait_t(6 * 2048);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_codec_intf
`default_nettype wire
